// File: rtl/rygar_pkg.sv
// Shared definitions for the rygar download path: packer FSM states and word geometry.
package rygar_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_BITS      = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FINAL = 2'd2
  } packer_state_e;
endpackage

// File: rtl/download_packer.sv
// Packs the HPS byte download stream into little-endian 32-bit SDRAM writes.
// Request rises 1 cycle after the completing byte; ioctl_wait holds the HPS off while a write is outstanding.
module download_packer
  import rygar_pkg::*;
#(
  parameter int IOCTL_ADDR_WIDTH = 25,
  parameter int SDRAM_ADDR_WIDTH = 23
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]                  ioctl_data,
  input  logic                        ioctl_wr,
  input  logic                        ioctl_download,
  output logic                        ioctl_wait,
  output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic [31:0]                 sdram_data,
  output logic                        sdram_we,
  output logic                        sdram_req,
  input  logic                        sdram_ack,
  output logic                        done
);

  packer_state_e               state;
  logic [31:0]                 acc;
  logic [BYTES_PER_WORD-1:0]   vld;
  logic [SDRAM_ADDR_WIDTH-1:0] acc_addr;
  logic                        dl_q;
  logic                        end_pend;

  logic                        wr_ok, rise, fall, end_now, disc, can_load, full_flush;
  logic [LANE_BITS-1:0]        lane;
  logic [SDRAM_ADDR_WIDTH-1:0] waddr, merge_addr;
  logic [31:0]                 acc_base, merge_acc, byte_word;
  logic [BYTES_PER_WORD-1:0]   vld_base, merge_vld, byte_vld;

  assign wr_ok    = ioctl_wr && ioctl_download;
  assign rise     = ioctl_download && !dl_q;
  assign fall     = dl_q && !ioctl_download;
  assign end_now  = fall || end_pend;
  assign lane     = ioctl_addr[LANE_BITS-1:0];
  assign waddr    = SDRAM_ADDR_WIDTH'(ioctl_addr[IOCTL_ADDR_WIDTH-1:LANE_BITS]);
  // An ack in the same cycle frees the write register, so a new flush may load then.
  assign can_load = (state == ST_IDLE) || (state == ST_REQ && sdram_ack);

  assign sdram_req  = (state != ST_IDLE);
  assign sdram_we   = sdram_req;
  assign ioctl_wait = (state != ST_IDLE);

  always_comb begin
    acc_base  = rise ? '0 : acc;
    vld_base  = rise ? '0 : vld;
    byte_word = '0;
    byte_word[8*lane +: 8] = ioctl_data;
    byte_vld  = '0;
    byte_vld[lane] = 1'b1;
    disc       = wr_ok && (|vld_base) && (waddr != acc_addr);
    merge_acc  = acc_base;
    merge_vld  = vld_base;
    merge_addr = acc_addr;
    if (wr_ok && !disc) begin
      merge_acc[8*lane +: 8] = ioctl_data;
      merge_vld  = vld_base | byte_vld;
      merge_addr = waddr;
    end
    full_flush = merge_vld[BYTES_PER_WORD-1] && !disc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      vld        <= '0;
      acc_addr   <= '0;
      dl_q       <= 1'b0;
      end_pend   <= 1'b0;
      done       <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
    end else begin
      dl_q     <= ioctl_download;
      done     <= 1'b0;
      acc      <= merge_acc;
      vld      <= merge_vld;
      acc_addr <= merge_addr;
      end_pend <= end_pend || fall;
      if (can_load) begin
        state <= ST_IDLE;
        if (disc) begin
          // Old word goes out now; the new byte starts a fresh accumulator.
          sdram_addr <= acc_addr;
          sdram_data <= acc_base;
          acc        <= byte_word;
          vld        <= byte_vld;
          acc_addr   <= waddr;
          state      <= ST_REQ;
        end else if (full_flush) begin
          sdram_addr <= merge_addr;
          sdram_data <= merge_acc;
          acc        <= '0;
          vld        <= '0;
          state      <= ST_REQ;
        end else if (end_now && (|merge_vld)) begin
          sdram_addr <= merge_addr;
          sdram_data <= merge_acc;
          acc        <= '0;
          vld        <= '0;
          end_pend   <= 1'b0;
          state      <= ST_FINAL;
        end else if (end_now) begin
          done     <= 1'b1;
          end_pend <= 1'b0;
        end
      end else if (state == ST_FINAL && sdram_ack) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_download_packer.sv
// Directed bench for download_packer with an expected-write scoreboard.
module tb_download_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        done;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  total  = 0;
  int  passed = 0;

  download_packer #(.IOCTL_ADDR_WIDTH(25), .SDRAM_ADDR_WIDTH(23)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_download (ioctl_download),
    .ioctl_wait     (ioctl_wait),
    .sdram_addr     (sdram_addr),
    .sdram_data     (sdram_data),
    .sdram_we       (sdram_we),
    .sdram_req      (sdram_req),
    .sdram_ack      (sdram_ack),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic push(input logic [22:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Waits for a request, holds it for 'delay' cycles, acks, and scores the write.
  task automatic serve(input int delay, input logic last);
    wr_t e;
    int  n;
    n = 0;
    while (!sdram_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", sdram_req, 1);
    if (sdram_req) begin
      repeat (delay) begin
        chk("wait_in_req", ioctl_wait, 1);
        tick();
      end
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("we", sdram_we, 1);
        chk("addr", sdram_addr, e.addr);
        chk("data", sdram_data, e.data);
      end
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("done_after_ack", done, last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    wr_t e;
    reset_n        = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    sdram_ack      = 1'b0;
    #7;
    chk("rst_req",  sdram_req,  0);
    chk("rst_we",   sdram_we,   0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", done,       0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data", sdram_data, 0);
    tick();
    reset_n = 1'b1;
    ioctl_download = 1'b1;
    tick();

    // Full word at addresses 0..3
    push(23'd0, 32'h44332211);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    wr_byte(25'd2, 8'h33);
    chk("no_req_partial", sdram_req, 0);
    wr_byte(25'd3, 8'h44);
    chk("req_latency", sdram_req, 1);
    serve(3, 1'b0);
    chk("req_dropped", sdram_req, 0);
    chk("wait_dropped", ioctl_wait, 0);

    // Partial word flushed at end of download
    push(23'd2, 32'h0000BBAA);
    wr_byte(25'd8, 8'hAA);
    wr_byte(25'd9, 8'hBB);
    ioctl_download = 1'b0;
    tick();
    serve(2, 1'b1);
    tick();
    chk("done_one_cycle", done, 0);

    // Address discontinuity
    ioctl_download = 1'b1;
    tick();
    push(23'd1, 32'h00000055);
    wr_byte(25'd4, 8'h55);
    wr_byte(25'd16, 8'h66);
    chk("disc_req", sdram_req, 1);
    serve(1, 1'b0);
    push(23'd4, 32'h00000066);
    ioctl_download = 1'b0;
    tick();
    serve(0, 1'b1);

    // Ack and write in the same cycle
    ioctl_download = 1'b1;
    tick();
    push(23'd5, 32'h04030201);
    wr_byte(25'd20, 8'h01);
    wr_byte(25'd21, 8'h02);
    wr_byte(25'd22, 8'h03);
    wr_byte(25'd23, 8'h04);
    chk("sim_req", sdram_req, 1);
    e = sb.pop_front();
    chk("sim_addr", sdram_addr, e.addr);
    chk("sim_data", sdram_data, e.data);
    sdram_ack  = 1'b1;
    ioctl_addr = 25'd24;
    ioctl_data = 8'h77;
    ioctl_wr   = 1'b1;
    tick();
    sdram_ack  = 1'b0;
    ioctl_wr   = 1'b0;
    chk("sim_req_drop", sdram_req, 0);
    push(23'd6, 32'h00008877);
    wr_byte(25'd25, 8'h88);
    chk("sim_no_req", sdram_req, 0);
    ioctl_download = 1'b0;
    tick();
    serve(1, 1'b1);

    // Download ends while a request is pending and residue remains
    ioctl_download = 1'b1;
    tick();
    push(23'd16, 32'h000000A1);
    push(23'd17, 32'h000000B2);
    wr_byte(25'h40, 8'hA1);
    wr_byte(25'h44, 8'hB2);
    ioctl_download = 1'b0;
    tick();
    serve(2, 1'b0);
    serve(1, 1'b1);

    // Empty download: done one cycle after the falling edge
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("empty_done", done, 1);
    chk("empty_no_req", sdram_req, 0);

    // Write while not downloading is ignored
    wr_byte(25'h30, 8'hEE);
    chk("ignored_req", sdram_req, 0);
    chk("ignored_wait", ioctl_wait, 0);
    ioctl_download = 1'b1;
    tick();
    push(23'd12, 32'h99000000);
    wr_byte(25'h33, 8'h99);
    serve(0, 1'b0);

    // Reset mid-request abandons it; stray ack afterwards does nothing
    wr_byte(25'h50, 8'h10);
    wr_byte(25'h51, 8'h20);
    wr_byte(25'h52, 8'h30);
    wr_byte(25'h53, 8'h40);
    chk("pre_rst_req", sdram_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req",  sdram_req,  0);
    chk("arst_we",   sdram_we,   0);
    chk("arst_wait", ioctl_wait, 0);
    chk("arst_done", done,       0);
    tick();
    reset_n = 1'b1;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    repeat (3) begin
      chk("stray_ack_req", sdram_req, 0);
      chk("stray_ack_done", done, 0);
      tick();
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
